// File: rtl/rob_commit_if.sv
// rtl/rob_commit_if.sv - dispatch/complete/retire bundle between rename, CDB, free list and the ROB
interface rob_commit_if #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 5,
    parameter int AREG_W = 5
);
    localparam int TAG_W = $clog2(DEPTH);

    logic              dispatch_valid;
    logic [AREG_W-1:0] dispatch_arch_dest;
    logic [PREG_W-1:0] dispatch_phys_dest;
    logic [PREG_W-1:0] dispatch_phys_old;
    logic              dispatch_ready;
    logic [TAG_W-1:0]  dispatch_tag;
    logic              complete_valid;
    logic [TAG_W-1:0]  complete_tag;
    logic              retire_valid;
    logic [AREG_W-1:0] retire_arch_dest;
    logic [PREG_W-1:0] retire_phys_dest;
    logic              commit_flag;
    logic [PREG_W-1:0] commit_phys_reg;
    logic [TAG_W:0]    count;

    modport master (
        output dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
        output complete_valid, complete_tag,
        input  dispatch_ready, dispatch_tag, retire_valid, retire_arch_dest, retire_phys_dest,
        input  commit_flag, commit_phys_reg, count
    );

    modport slave (
        input  dispatch_valid, dispatch_arch_dest, dispatch_phys_dest, dispatch_phys_old,
        input  complete_valid, complete_tag,
        output dispatch_ready, dispatch_tag, retire_valid, retire_arch_dest, retire_phys_dest,
        output commit_flag, commit_phys_reg, count
    );
endinterface

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - in-order reorder buffer with single-retire commit and free-list return
module rob_commit #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = 5,
    parameter int AREG_W = 5
) (
    input  logic         clk,
    input  logic         reset,
    rob_commit_if.slave  rob
);
    localparam int TAG_W = $clog2(DEPTH);
    localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  valid_q;
    logic [DEPTH-1:0]  done_q;
    logic [AREG_W-1:0] arch_q [DEPTH];
    logic [PREG_W-1:0] phys_q [DEPTH];
    logic [PREG_W-1:0] old_q  [DEPTH];
    logic [TAG_W-1:0]  head_q;
    logic [TAG_W-1:0]  tail_q;
    logic [TAG_W:0]    count_q;

    logic alloc;
    logic retire;

    // Every output below depends only on registered state, never on this cycle's inputs.
    assign rob.dispatch_ready   = (count_q != FULL_COUNT);
    assign rob.dispatch_tag     = tail_q;
    assign rob.count            = count_q;
    assign retire               = valid_q[head_q] && done_q[head_q];
    assign rob.retire_valid     = retire;
    assign rob.retire_arch_dest = arch_q[head_q];
    assign rob.retire_phys_dest = phys_q[head_q];
    assign rob.commit_phys_reg  = retire ? old_q[head_q] : '0;
    // Physical register 0 is the permanent x0 mapping and must never re-enter the free list.
    assign rob.commit_flag      = retire && (old_q[head_q] != '0);

    assign alloc = rob.dispatch_valid && rob.dispatch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                arch_q[i] <= '0;
                phys_q[i] <= '0;
                old_q[i]  <= '0;
            end
        end else begin
            // Completion to a not-yet-valid entry (including the one being allocated) is dropped.
            if (rob.complete_valid && valid_q[rob.complete_tag]) begin
                done_q[rob.complete_tag] <= 1'b1;
            end
            if (retire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (alloc) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                arch_q[tail_q]  <= rob.dispatch_arch_dest;
                phys_q[tail_q]  <= rob.dispatch_phys_dest;
                old_q[tail_q]   <= rob.dispatch_phys_old;
                tail_q          <= tail_q + 1'b1;
            end
            case ({alloc, retire})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed self-checking bench for rob_commit
module tb_rob_commit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    rob_commit_if #(.DEPTH(8), .PREG_W(5), .AREG_W(5)) rif ();

    rob_commit #(.DEPTH(8), .PREG_W(5), .AREG_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .rob   (rif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dispatch(input int a, input int p, input int o);
        rif.dispatch_valid     = 1'b1;
        rif.dispatch_arch_dest = 5'(a);
        rif.dispatch_phys_dest = 5'(p);
        rif.dispatch_phys_old  = 5'(o);
        tick();
        rif.dispatch_valid     = 1'b0;
    endtask

    task automatic complete(input int t);
        rif.complete_valid = 1'b1;
        rif.complete_tag   = 3'(t);
        tick();
        rif.complete_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1;
        rif.dispatch_valid     = 1'b0;
        rif.dispatch_arch_dest = '0;
        rif.dispatch_phys_dest = '0;
        rif.dispatch_phys_old  = '0;
        rif.complete_valid     = 1'b0;
        rif.complete_tag       = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        chk("rst_ready", rif.dispatch_ready, 1);
        chk("rst_tag", rif.dispatch_tag, 0);
        chk("rst_retire", rif.retire_valid, 0);
        chk("rst_cflag", rif.commit_flag, 0);
        chk("rst_creg", rif.commit_phys_reg, 0);
        chk("rst_arch", rif.retire_arch_dest, 0);
        chk("rst_phys", rif.retire_phys_dest, 0);
        chk("rst_count", rif.count, 0);

        // single commit: arch 3, phys 7, old 2 at tag 0
        chk("single_tag", rif.dispatch_tag, 0);
        dispatch(3, 7, 2);
        chk("single_cnt1", rif.count, 1);
        chk("single_noret", rif.retire_valid, 0);
        complete(0);
        chk("single_rv", rif.retire_valid, 1);
        chk("single_cflag", rif.commit_flag, 1);
        chk("single_creg", rif.commit_phys_reg, 2);
        chk("single_phys", rif.retire_phys_dest, 7);
        chk("single_arch", rif.retire_arch_dest, 3);
        tick();
        chk("single_cnt0", rif.count, 0);
        chk("single_rv0", rif.retire_valid, 0);

        // x0 suppression at tag 1
        dispatch(4, 9, 0);
        complete(1);
        chk("x0_rv", rif.retire_valid, 1);
        chk("x0_cflag", rif.commit_flag, 0);
        chk("x0_creg", rif.commit_phys_reg, 0);
        tick();
        chk("x0_cnt", rif.count, 0);

        // out-of-order completion on tags 2,3,4
        chk("ooo_tag2", rif.dispatch_tag, 2);
        dispatch(1, 20, 10);
        chk("ooo_tag3", rif.dispatch_tag, 3);
        dispatch(2, 21, 11);
        chk("ooo_tag4", rif.dispatch_tag, 4);
        dispatch(3, 22, 12);
        complete(4);
        chk("ooo_hold4", rif.retire_valid, 0);
        complete(3);
        chk("ooo_hold3", rif.retire_valid, 0);
        complete(2);
        chk("ooo_rv_a", rif.retire_valid, 1);
        chk("ooo_creg_a", rif.commit_phys_reg, 10);
        tick();
        chk("ooo_rv_b", rif.retire_valid, 1);
        chk("ooo_creg_b", rif.commit_phys_reg, 11);
        chk("ooo_cnt_b", rif.count, 2);
        tick();
        chk("ooo_rv_c", rif.retire_valid, 1);
        chk("ooo_creg_c", rif.commit_phys_reg, 12);
        chk("ooo_cnt_c", rif.count, 1);
        tick();
        chk("ooo_rv_d", rif.retire_valid, 0);
        chk("ooo_cnt_d", rif.count, 0);

        // spurious completion to unallocated tag 6, then fill all 8 entries from tag 5
        complete(6);
        chk("spur_cnt", rif.count, 0);
        chk("spur_rv", rif.retire_valid, 0);
        for (int i = 0; i < 8; i++) dispatch(i, 16 + i, i + 1);
        chk("full_cnt", rif.count, 8);
        chk("full_ready", rif.dispatch_ready, 0);
        dispatch(9, 9, 9);
        chk("full_cnt_hold", rif.count, 8);
        chk("full_tag_hold", rif.dispatch_tag, 5);
        complete(5);
        chk("full_rv", rif.retire_valid, 1);
        chk("full_creg", rif.commit_phys_reg, 1);
        chk("full_ready_still0", rif.dispatch_ready, 0);
        tick();
        chk("full_ready_after", rif.dispatch_ready, 1);
        chk("full_cnt7", rif.count, 7);
        chk("spur_ignored", rif.retire_valid, 0);
        for (int i = 0; i < 7; i++) complete((6 + i) % 8);
        tick();
        chk("drain_cnt", rif.count, 0);

        // steady state: dispatch e_i and complete e_{i-1} every cycle, tags start at 5
        for (int i = 0; i < 22; i++) begin
            rif.dispatch_valid     = 1'b1;
            rif.dispatch_arch_dest = 5'(i);
            rif.dispatch_phys_dest = 5'(i + 8);
            rif.dispatch_phys_old  = 5'(i + 1);
            rif.complete_valid     = (i > 0);
            rif.complete_tag       = 3'((5 + i - 1) % 8);
            chk($sformatf("ss_tag%0d", i), rif.dispatch_tag, (5 + i) % 8);
            if (i >= 2) begin
                chk($sformatf("ss_rv%0d", i), rif.retire_valid, 1);
                chk($sformatf("ss_creg%0d", i), rif.commit_phys_reg, i - 1);
            end
            tick();
            if (i >= 2) chk($sformatf("ss_cnt%0d", i), rif.count, 2);
        end
        rif.complete_valid = 1'b0;

        // build 5 in flight (e20 retires during the first of these edges)
        for (int i = 0; i < 4; i++) begin
            rif.dispatch_arch_dest = 5'(i);
            rif.dispatch_phys_dest = 5'(i + 24);
            rif.dispatch_phys_old  = 5'(i + 24);
            tick();
        end
        rif.dispatch_valid = 1'b0;
        chk("mid_cnt5", rif.count, 5);
        chk("mid_tag", rif.dispatch_tag, 7);

        // complete head e21 (tag 2) while reset is asserted at the same edge
        rif.complete_valid = 1'b1;
        rif.complete_tag   = 3'd2;
        reset = 1'b1;
        tick();
        rif.complete_valid = 1'b0;
        chk("mrst_cnt", rif.count, 0);
        chk("mrst_cflag", rif.commit_flag, 0);
        chk("mrst_rv", rif.retire_valid, 0);
        chk("mrst_tag", rif.dispatch_tag, 0);
        chk("mrst_arch", rif.retire_arch_dest, 0);
        reset = 1'b0;
        tick();
        chk("post_cnt", rif.count, 0);
        chk("post_ready", rif.dispatch_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rob_commit.md
# rob_commit

In-order reorder buffer and commit stage for the Tomasulo core. It allocates one entry per renamed instruction and records CDB completions by tag. It retires entries strictly in program order, at most one per cycle. On each retirement it returns the superseded physical register to the rename free list via `commit_flag`/`commit_phys_reg`, closing the allocate→free loop opened by renaming.

## Interface
Parameters:
- `DEPTH`, 8: number of ROB entries; power of two, ≥2.
- `PREG_W`, 5: physical register index width.
- `AREG_W`, 5: architectural register index width.
- `TAG_W`, $clog2(DEPTH): ROB tag width (derived).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `dispatch_valid`  in  1  renamed instruction presented for allocation.
- `dispatch_arch_dest`  in  AREG_W  architectural destination.
- `dispatch_phys_dest`  in  PREG_W  newly assigned physical destination.
- `dispatch_phys_old`  in  PREG_W  previous mapping of the destination (`dest_old` from RAT).
- `dispatch_ready`  out  1  ROB can accept an entry this cycle.
- `dispatch_tag`  out  TAG_W  tag given to the entry accepted this cycle (= tail).
- `complete_valid`  in  1  CDB broadcast valid.
- `complete_tag`  in  TAG_W  ROB tag of the completing instruction.
- `retire_valid`  out  1  head entry retires this cycle.
- `retire_arch_dest`  out  AREG_W  head architectural destination.
- `retire_phys_dest`  out  PREG_W  head physical destination.
- `commit_flag`  out  1  free-list return strobe.
- `commit_phys_reg`  out  PREG_W  physical register returned to the free list.
- `count`  out  TAG_W+1  occupied entries.

## Operation
- Storage per entry: `valid`, `done`, `arch_dest`, `phys_dest`, `phys_old`. Pointers `head` and `tail` are TAG_W bits and wrap naturally modulo DEPTH. `count` is a 0..DEPTH register.
- **Allocate:** `dispatch_ready = (count != DEPTH)`, computed from the registered count only. A full ROB that retires in the same cycle is still not ready. When `dispatch_valid && dispatch_ready`, the entry at `tail` is written with `valid=1`, `done=0` and the fields; then `tail++`. `dispatch_tag = tail` at all times.
- **Complete:** when `complete_valid`, set `done[complete_tag]`, but only if that entry is valid. A completion on an invalid entry is ignored. A repeated completion on an already-done entry has no effect.
- **Retire:** `retire_valid = valid[head] && done[head]`. When asserted, the entry is cleared and `head++`.
  - `retire_*` outputs always show the head fields.
  - `commit_phys_reg = phys_old[head]` whenever `retire_valid`, else 0.
  - `commit_flag = retire_valid && (phys_old[head] != 0)`. Physical register 0 is the hardwired x0/reset mapping and is never returned.
- **Count:** `count_next = count + alloc - retire`.
  - Allocate and retire in the same cycle leave count unchanged.
  - Allocate and retire may target the same index only when count==0. That case cannot occur, because retire requires a valid head.
- **Complete vs. retire:** a completion and a retire at the same index in one cycle cannot coexist, since retire needs `done` already set. A completion at a non-head index proceeds in parallel with a retire.
- **Complete vs. allocate:** a completion to the tag being allocated this cycle is ignored, because the entry is not yet valid. Allocation overwrites `done` to 0.

## Timing
- Reset: all `valid`/`done` = 0, `head = tail = 0`, `count = 0`. Outputs after reset:
  - `dispatch_ready = 1`, `dispatch_tag = 0`.
  - `retire_valid = commit_flag = 0`, `commit_phys_reg = 0`.
  - `retire_arch_dest`/`retire_phys_dest` = 0.
- A reset asserted mid-operation discards every in-flight entry at that edge. No returns are issued.
- Allocate: entry visible (valid) the cycle after the accepting edge.
- Complete: `complete_valid` at edge N sets `done`. If the entry is the head, `retire_valid`/`commit_flag` are high combinationally during cycle N+1, and the free list consumes them at edge N+1.
- Minimum dispatch-to-retire latency is 2 edges: allocate at N, complete at N+1, retire at N+2. Throughput is one retire per cycle.
- `dispatch_ready`, `dispatch_tag`, `retire_*` and `commit_*` are combinational from registered state only. There is no combinational path from any input to these outputs.

## Test plan
- **Reset and single commit:** reset, then dispatch `{arch 3, phys 7, old 2}` → `dispatch_tag = 0`. Complete tag 0 → next cycle `retire_valid=1`, `commit_flag=1`, `commit_phys_reg=2`, `retire_phys_dest=7`. Then `count=0`.
- **x0 suppression:** dispatch with `old=0`, then complete it → `retire_valid=1`, `commit_flag=0`, `commit_phys_reg=0`.
- **Out-of-order completion:** dispatch tags 0, 1, 2. Complete 2, then 1 → no retire. Complete 0 → retires 0, 1, 2 on three consecutive cycles, in order.
- **Full:** dispatch 8 entries → `count=8`, `dispatch_ready=0`. A further `dispatch_valid` is not accepted. Complete the head → `dispatch_ready=1` only after the retire edge.
- **Simultaneous dispatch, retire and wrap:** keep steady state with one dispatch and one completed-head retire per cycle for 20 cycles → `count` constant, `dispatch_tag` wraps 7→0, `commit_phys_reg` sequence matches the dispatched `old` values.
- **Spurious and mid-run events:** a completion to an unallocated tag has no effect. Reset asserted with 5 entries in flight → next cycle `count=0` and `commit_flag=0`.
